// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator with frame pulse/counter
//
// Ports:
//   vga_clk      in   pixel clock, sole clock domain
//   reset        in   synchronous active-high reset, overrides en
//   en           in   pixel advance enable
//   DrawX        out  [9:0] horizontal position, 0..H_TOTAL-1
//   DrawY        out  [9:0] vertical position, 0..V_TOTAL-1
//   blank        out  1 while (DrawX, DrawY) lies in the visible area
//   hs, vs       out  sync pulses, SYNC_POL level inside the sync regions
//   frame_start  out  one-cycle pulse when the raster wraps to (0,0)
//   frame_count  out  [7:0] completed frames since reset, mod 256
//
// Every output is a flop. blank/hs/vs are decoded from the *next* counter
// values so they line up with DrawX/DrawY in the same cycle.

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide; anything larger cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region boundaries are kept 11 bits wide so an end boundary of exactly
    // 1024 (zero back porch at the maximum total) still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        h_last;
    logic        v_last;
    logic        frame_wrap;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        visible_next;
    logic        hsync_next;
    logic        vsync_next;

    // Next raster position. With en low the position simply holds, which
    // also makes the decoded blank/hs/vs hold.
    always_comb begin
        x_next     = DrawX;
        y_next     = DrawY;
        h_last     = (DrawX == H_LAST);
        v_last     = (DrawY == V_LAST);
        frame_wrap = 1'b0;
        if (en) begin
            if (h_last) begin
                x_next = '0;
                if (v_last) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = DrawY + 10'd1;
                end
            end else begin
                x_next = DrawX + 10'd1;
            end
        end
    end

    // Region decode on the upcoming position; vs looks at the line only.
    always_comb begin
        x_ext        = {1'b0, x_next};
        y_ext        = {1'b0, y_next};
        visible_next = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
        hsync_next   = (x_ext >= H_HS_START) && (x_ext < H_HS_END);
        vsync_next   = (y_ext >= V_VS_START) && (y_ext < V_VS_END);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            blank       <= visible_next;
            hs          <= hsync_next ? SYNC_POL : ~SYNC_POL;
            vs          <= vsync_next ? SYNC_POL : ~SYNC_POL;
            // frame_wrap already requires en, so a stall never stretches it.
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (full-size and shrunken raster)

module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Full-size 640x480 instance
    logic       rst_a = 1'b1;
    logic       en_a  = 1'b0;
    logic [9:0] x_a, y_a;
    logic       blank_a, hs_a, vs_a, fs_a;
    logic [7:0] fc_a;

    // Shrunken raster: 16 x 10 total, visible 8 x 6, hs on x 10..12, vs on y 7..8
    logic       rst_b = 1'b1;
    logic       en_b  = 1'b0;
    logic [9:0] x_b, y_b;
    logic       blank_b, hs_b, vs_b, fs_b;
    logic [7:0] fc_b;

    vga_timing_gen dut_full (
        .vga_clk     (vga_clk),
        .reset       (rst_a),
        .en          (en_a),
        .DrawX       (x_a),
        .DrawY       (y_a),
        .blank       (blank_a),
        .hs          (hs_a),
        .vs          (vs_a),
        .frame_start (fs_a),
        .frame_count (fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3),
        .V_VISIBLE (6),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .SYNC_POL  (1'b0)
    ) dut_small (
        .vga_clk     (vga_clk),
        .reset       (rst_b),
        .en          (en_b),
        .DrawX       (x_b),
        .DrawY       (y_b),
        .blank       (blank_b),
        .hs          (hs_b),
        .vs          (vs_b),
        .frame_start (fs_b),
        .frame_count (fc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    initial begin
        int ex, ey;
        int hs_bad, hs_low;
        int pos_bad, blank_cnt, blank_bad, vs_low, vs_bad, fs_cnt, fs_bad;
        int fs_seen, fc_bad, saw255;

        // ---------------- full-size instance ----------------
        @(negedge vga_clk);
        repeat (3) tick();
        check("rst_x",     int'(x_a),     0);
        check("rst_y",     int'(y_a),     0);
        check("rst_blank", int'(blank_a), 1);
        check("rst_hs",    int'(hs_a),    1);
        check("rst_vs",    int'(vs_a),    1);
        check("rst_fs",    int'(fs_a),    0);
        check("rst_fc",    int'(fc_a),    0);

        rst_a = 1'b0;
        en_a  = 1'b1;
        tick();
        check("first_x", int'(x_a), 1);

        hs_bad = 0;
        hs_low = 0;
        for (int c = 2; c <= 800; c++) begin
            tick();
            ex = c % 800;
            if (c == 639) check("blank_639", int'(blank_a), 1);
            if (c == 640) begin
                check("x_640",     int'(x_a),     640);
                check("blank_640", int'(blank_a), 0);
            end
            if (c == 799) check("x_799", int'(x_a), 799);
            if (int'(hs_a) != ((ex >= 656 && ex < 752) ? 0 : 1)) hs_bad++;
            if (!hs_a) hs_low++;
        end
        check("hs_region_bad", hs_bad, 0);
        check("hs_low_count",  hs_low, 96);
        check("wrap_x",        int'(x_a), 0);
        check("wrap_y",        int'(y_a), 1);

        repeat (7300) tick();
        check("stall_pos_x", int'(x_a), 100);
        check("stall_pos_y", int'(y_a), 10);

        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_x",     int'(x_a),     100);
            check("stall_y",     int'(y_a),     10);
            check("stall_blank", int'(blank_a), 1);
            check("stall_hs",    int'(hs_a),    1);
            check("stall_vs",    int'(vs_a),    1);
        end
        en_a = 1'b1;
        tick();
        check("resume_x", int'(x_a), 101);
        check("resume_y", int'(y_a), 10);
        en_a = 1'b0;

        // ---------------- shrunken instance ----------------
        check("s_rst_x",  int'(x_b),     0);
        check("s_rst_bl", int'(blank_b), 1);
        check("s_rst_fc", int'(fc_b),    0);

        rst_b = 1'b0;
        en_b  = 1'b1;
        ex = 0; ey = 0;
        pos_bad = 0; blank_cnt = 0; blank_bad = 0;
        vs_low = 0; vs_bad = 0; fs_cnt = 0; fs_bad = 0;
        for (int t = 1; t <= 160; t++) begin
            tick();
            ex++;
            if (ex == 16) begin
                ex = 0;
                ey++;
                if (ey == 10) ey = 0;
            end
            if (int'(x_b) != ex || int'(y_b) != ey) pos_bad++;
            if (blank_b) blank_cnt++;
            if (int'(blank_b) != ((ex < 8 && ey < 6) ? 1 : 0)) blank_bad++;
            if (!vs_b) vs_low++;
            if (int'(vs_b) != ((ey == 7 || ey == 8) ? 0 : 1)) vs_bad++;
            if (fs_b) begin
                fs_cnt++;
                if (ex != 0 || ey != 0) fs_bad++;
            end
        end
        check("s_pos_bad",   pos_bad,   0);
        check("s_blank_cnt", blank_cnt, 48);
        check("s_blank_bad", blank_bad, 0);
        check("s_vs_low",    vs_low,    32);
        check("s_vs_bad",    vs_bad,    0);
        check("s_fs_cnt",    fs_cnt,    1);
        check("s_fs_bad",    fs_bad,    0);
        check("s_fs_now",    int'(fs_b), 1);
        check("s_fc_1",      int'(fc_b), 1);

        en_b = 1'b0;
        tick();
        check("s_fs_stall", int'(fs_b), 0);
        check("s_fc_stall", int'(fc_b), 1);
        check("s_x_stall",  int'(x_b),  0);
        en_b = 1'b1;
        tick();
        check("s_fs_gone", int'(fs_b), 0);
        repeat (52) tick();
        check("s_mid_x", int'(x_b), 5);
        check("s_mid_y", int'(y_b), 3);

        rst_b = 1'b1;
        tick();
        check("s_mrst_x",  int'(x_b),     0);
        check("s_mrst_y",  int'(y_b),     0);
        check("s_mrst_fc", int'(fc_b),    0);
        check("s_mrst_fs", int'(fs_b),    0);
        check("s_mrst_bl", int'(blank_b), 1);
        check("s_mrst_hs", int'(hs_b),    1);

        rst_b = 1'b0;
        fs_seen = 0; fc_bad = 0; saw255 = 0;
        for (int t = 1; t <= 40960; t++) begin
            tick();
            if (fs_b) begin
                fs_seen++;
                if (int'(fc_b) != (fs_seen % 256)) fc_bad++;
                if (fc_b == 8'd255) saw255 = 1;
            end
        end
        check("s_256_pulses", fs_seen,    256);
        check("s_256_fc_bad", fc_bad,     0);
        check("s_256_saw255", saw255,     1);
        check("s_256_fc",     int'(fc_b), 0);
        check("s_256_fs",     int'(fs_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
